// File: rtl/round_robin_arbiter_pkg.sv
// Shared types for the round-robin arbiter: 8-bit index word and FSM states.
package round_robin_arbiter_pkg;

    localparam int unsigned IDX_W = 8;

    typedef logic [IDX_W-1:0] w8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick_first.sv
// Find-first eligible channel starting at ptr, wrapping to the lowest index below ptr.
module rr_pick_first
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned N_CH = 8
) (
    input  logic [N_CH-1:0] eligible,
    input  w8               ptr,
    output w8               idx,
    output logic            none
);

    logic hi_found;
    logic lo_found;
    w8    hi_idx;
    w8    lo_idx;

    // Pass one takes the first hit at/above ptr, pass two the first hit below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (eligible[i]) begin
                if (w8'(i) >= ptr) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = w8'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = w8'(i);
                end
            end
        end
    end

    assign idx  = hi_found ? hi_idx : lo_idx;
    assign none = !(hi_found || lo_found);

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with sticky valid/ready grant and back-to-back handoff.
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int unsigned N_CH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] mask,
    output logic            grant_valid,
    input  logic            grant_ready,
    output w8               grant_idx,
    output logic [N_CH-1:0] grant_onehot
);

    localparam w8 LAST_IDX = w8'(N_CH - 1);

    state_e          state_q;
    state_e          state_d;
    w8               ptr_q;
    w8               ptr_d;
    w8               grant_idx_q;
    w8               grant_idx_d;

    logic [N_CH-1:0] eligible;
    logic            handshake;
    w8               ptr_sel;
    w8               pick_idx;
    logic            pick_none;

    assign eligible  = req & ~mask;
    assign handshake = (state_q == ST_GRANT) && grant_ready;

    // On a handshake the picker already sees the advanced pointer, enabling one grant per cycle.
    always_comb begin
        ptr_sel = ptr_q;
        if (handshake) begin
            ptr_sel = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + w8'(1);
        end
    end

    rr_pick_first #(
        .N_CH (N_CH)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_sel),
        .idx      (pick_idx),
        .none     (pick_none)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (!pick_none) begin
                    state_d     = ST_GRANT;
                    grant_idx_d = pick_idx;
                end
            end
            ST_GRANT: begin
                // Offer is sticky until accepted; req/mask changes are ignored meanwhile.
                if (grant_ready) begin
                    ptr_d = ptr_sel;
                    if (pick_none) begin
                        state_d = ST_IDLE;
                    end else begin
                        grant_idx_d = pick_idx;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign grant_valid = (state_q == ST_GRANT);
    assign grant_idx   = grant_idx_q;

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            grant_onehot[i] = grant_valid && (grant_idx_q == w8'(i));
        end
    end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter (N_CH=8 and N_CH=1 instances).
module tb_round_robin_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] mask;
    logic       grant_ready;
    logic       grant_valid;
    logic [7:0] grant_idx;
    logic [7:0] grant_onehot;

    logic [0:0] req1;
    logic [0:0] mask1;
    logic       ready1;
    logic       valid1;
    logic [7:0] idx1;
    logic [0:0] onehot1;

    int checks;
    int errors;

    round_robin_arbiter #(.N_CH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .mask         (mask),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    round_robin_arbiter #(.N_CH(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .req          (req1),
        .mask         (mask1),
        .grant_valid  (valid1),
        .grant_ready  (ready1),
        .grant_idx    (idx1),
        .grant_onehot (onehot1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one unit after an edge, so the pulse never overlaps a clock edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic check_grant(input string tag, input logic [7:0] idx);
        check({tag, "_valid"}, 32'(grant_valid), 32'd1);
        check({tag, "_idx"}, 32'(grant_idx), 32'(idx));
        check({tag, "_onehot"}, 32'(grant_onehot), 32'(8'd1 << idx));
    endtask

    initial begin
        logic [7:0] seq_a [3];
        logic [7:0] seq_c [5];
        seq_a = '{8'd5, 8'd7, 8'd5};
        seq_c = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd4};
        checks = 0;
        errors = 0;
        reset = 1'b1;
        req = '0;
        mask = '0;
        grant_ready = 1'b0;
        req1 = '0;
        mask1 = '0;
        ready1 = 1'b0;

        repeat (2) tick();
        check("rst_valid", 32'(grant_valid), 32'd0);
        check("rst_idx", 32'(grant_idx), 32'd0);
        check("rst_onehot", 32'(grant_onehot), 32'd0);
        reset = 1'b0;

        // Sparse requests with wrap: 5, 7, 5
        req = 8'b1010_0000;
        grant_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_grant($sformatf("sparse%0d", i), seq_a[i]);
        end
        req = '0;
        tick();
        check("sparse_idle_valid", 32'(grant_valid), 32'd0);
        check("sparse_idle_onehot", 32'(grant_onehot), 32'd0);
        check("sparse_idle_idx_hold", 32'(grant_idx), 32'd5);
        tick();
        check("idle_ready_ignored", 32'(grant_valid), 32'd0);

        // Full rotation with continuous valid
        pulse_reset();
        req = 8'hFF;
        mask = 8'h00;
        grant_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_grant($sformatf("full%0d", i), 8'(i % 8));
        end

        // Sticky grant while req withdraws and mask closes
        pulse_reset();
        req = 8'h08;
        mask = 8'h00;
        grant_ready = 1'b0;
        tick();
        check_grant("sticky_start", 8'd3);
        req = 8'h00;
        mask = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("sticky%0d", i), 8'd3);
            req = (i % 2 == 0) ? 8'hFF : 8'h00;
        end
        req = 8'h00;
        grant_ready = 1'b1;
        tick();
        check("sticky_release_valid", 32'(grant_valid), 32'd0);
        check("sticky_release_onehot", 32'(grant_onehot), 32'd0);

        // Masked low half, then everything masked
        pulse_reset();
        req = 8'hFF;
        mask = 8'h0F;
        grant_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_grant($sformatf("masked%0d", i), seq_c[i]);
        end
        mask = 8'hFF;
        tick();
        check("masked_all_valid", 32'(grant_valid), 32'd0);

        // Asynchronous reset mid-grant
        pulse_reset();
        req = 8'h40;
        mask = 8'h00;
        grant_ready = 1'b0;
        tick();
        check_grant("async_pre", 8'd6);
        #1;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(grant_valid), 32'd0);
        check("async_idx", 32'(grant_idx), 32'd0);
        check("async_onehot", 32'(grant_onehot), 32'd0);
        #1;
        reset = 1'b0;
        req = 8'h41;
        grant_ready = 1'b1;
        tick();
        check_grant("async_post0", 8'd0);
        tick();
        check_grant("async_post1", 8'd6);
        req = '0;
        tick();

        // Single-channel instance
        pulse_reset();
        req1 = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("one%0d_valid", i), 32'(valid1), 32'd1);
            check($sformatf("one%0d_idx", i), 32'(idx1), 32'd0);
            check($sformatf("one%0d_onehot", i), 32'(onehot1), 32'd1);
        end
        req1 = 1'b0;
        tick();
        check("one_idle_valid", 32'(valid1), 32'd0);
        check("one_idle_onehot", 32'(onehot1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/round_robin_arbiter.md
ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 Parameter N_CH, default 8, meaning number of request channels; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  N_CH  per-channel request, bit i = channel i.
REQ-005 mask  input  N_CH  per-channel disable; 1 = channel ineligible.
REQ-006 grant_valid  output  1  a grant is being offered.
REQ-007 grant_ready  input  1  consumer accepts the offered grant.
REQ-008 grant_idx  output  8  index of granted channel (w8).
REQ-009 grant_onehot  output  N_CH  one-hot of grant_idx; all-zero when grant_valid=0.

Function
REQ-010 eligible = req & ~mask, evaluated combinationally each cycle.
REQ-011 Selection SHALL pick the lowest-index eligible bit at or above pointer ptr; if none, the lowest-index eligible bit below ptr (wrap-around).
REQ-012 The state machine SHALL have two states: IDLE (grant_valid=0) and GRANT (grant_valid=1).
REQ-013 IDLE, eligible nonzero at edge k: enter GRANT with the selected idx; grant_valid high after edge k (one-cycle latency).
REQ-014 IDLE, eligible zero: remain IDLE; grant_idx holds its last value, grant_onehot=0.
REQ-015 Handshake occurs at an edge where grant_valid=1 and grant_ready=1.
REQ-016 GRANT without handshake: grant_idx, grant_onehot, grant_valid held stable regardless of req/mask changes (sticky grant; withdrawal does not cancel).
REQ-017 On handshake: ptr <= grant_idx+1, wrapping to 0 when grant_idx = N_CH-1.
REQ-018 On handshake, the next winner SHALL be selected in the same edge using the updated pointer and current eligible; nonzero -> stay GRANT with new idx (back-to-back, 1 grant/cycle); zero -> IDLE.
REQ-019 A channel granted on a handshake SHALL not be re-granted on the next edge while any other channel is eligible (fairness).
REQ-020 Any eligible channel SHALL be granted within N_CH handshakes of becoming continuously eligible.
REQ-021 N_CH=1: grant_idx always 0; ptr fixed at 0; back-to-back grants to channel 0 permitted.
REQ-022 grant_ready while IDLE SHALL be ignored.

Reset
REQ-023 reset high SHALL immediately, without a clock edge, force state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, ptr=0.
REQ-024 Reset asserted mid-GRANT SHALL drop the offered grant without handshake; the first post-reset grant selects from ptr=0.
REQ-025 First eligible sampling SHALL occur at the first rising edge after reset deasserts.

Structure
REQ-026 w8 SHALL come from the shared typedefs header; no new package types are needed.
REQ-027 One sub-module, rr_pick_first (parameter N_CH), SHALL implement the masked two-pass find-first-from-pointer selection combinationally, outputting index (w8) and a none-found flag.
REQ-028 ptr, state, grant_idx SHALL be the only registers; grant_onehot derived from grant_idx and state.

Verification
REQ-029 N_CH=8, req=8'b1010_0000, ready=1 -> idx 5, then 7, then 5 (wrap), one per cycle.
REQ-030 N_CH=8, req=8'hFF, mask=0, ready held 1 -> idx sequence 0,1,2,...,7,0 with grant_valid continuously 1.
REQ-031 Grant idx 3 offered, ready=0 for 5 cycles while req toggles to 0 and mask to 8'hFF -> idx=3, onehot=8'h08, valid=1 all 5 cycles; handshake on cycle 6 then IDLE.
REQ-032 req=8'hFF, mask=8'h0F, ready=1 -> only idx 4..7 granted in rotation; mask=8'hFF -> valid drops after next handshake.
REQ-033 Reset pulsed between clock edges during GRANT idx 6 -> valid=0, idx=0 immediately; with req=8'h41 after release -> first grant idx 0, next idx 6.
REQ-034 N_CH=1, req=1, ready=1 -> idx 0 every cycle, valid continuously 1; req=0 -> IDLE after next handshake.
